// File: rtl/xalu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package xalu_pkg;

  localparam logic [2:0] XALU_MULT  = 3'b000;
  localparam logic [2:0] XALU_MULTU = 3'b001;
  localparam logic [2:0] XALU_DIV   = 3'b010;
  localparam logic [2:0] XALU_DIVU  = 3'b011;
  localparam logic [2:0] XALU_MTHI  = 3'b100;
  localparam logic [2:0] XALU_MTLO  = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } xalu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/xalu_muldiv.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed in the start cycle and held in pending registers;
// a down-counter models the latency and HI/LO only change on its terminal count.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation in flight; accepts MD ops and MTHI/MTLO writes
// RUN   | result pending; counter runs down, commit to HI/LO at zero
import xalu_pkg::*;

module xalu_muldiv #(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        XALU_Start,
  input  logic [2:0]  XALU_Op,
  output logic        XALU_Busy,
  output logic [31:0] XALU_HI,
  output logic [31:0] XALU_LO
);

  xalu_state_e        state;
  logic [31:0]        cnt;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_lo;

  logic [63:0]        a_sx;
  logic [63:0]        b_sx;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] sa;
  logic signed [31:0] sb_safe;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        ub_safe;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic               is_md;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic [31:0]        cnt_load;

  // Result datapath: everything is computed from the operands present at start.
  // Divisors of zero (and the signed overflow case) are replaced by 1 so the
  // operators never see an undefined division; their results are muxed out.
  always_comb begin
    a_sx     = {{32{A_E[31]}}, A_E};
    b_sx     = {{32{B_E[31]}}, B_E};
    prod_s   = a_sx * b_sx;
    prod_u   = {32'b0, A_E} * {32'b0, B_E};
    div_zero = (B_E == 32'd0);
    div_ovf  = (A_E == 32'h8000_0000) && (B_E == 32'hFFFF_FFFF);
    sa       = $signed(A_E);
    sb_safe  = (div_zero || div_ovf) ? 32'sd1 : $signed(B_E);
    q_s      = sa / sb_safe;
    r_s      = sa % sb_safe;
    ub_safe  = div_zero ? 32'd1 : B_E;
    q_u      = A_E / ub_safe;
    r_u      = A_E % ub_safe;

    is_md    = 1'b0;
    res_hi   = XALU_HI;
    res_lo   = XALU_LO;
    cnt_load = 32'(MULT_CYCLES - 1);
    case (XALU_Op)
      XALU_MULT: begin
        is_md            = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      XALU_MULTU: begin
        is_md            = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      XALU_DIV: begin
        is_md    = 1'b1;
        cnt_load = 32'(DIV_CYCLES - 1);
        if (div_ovf) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else if (!div_zero) begin
          res_lo = q_s;
          res_hi = r_s;
        end
      end
      XALU_DIVU: begin
        is_md    = 1'b1;
        cnt_load = 32'(DIV_CYCLES - 1);
        if (!div_zero) begin
          res_lo = q_u;
          res_hi = r_u;
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered busy and HI/LO; reset aborts any pending commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      XALU_Busy <= 1'b0;
      XALU_HI   <= 32'd0;
      XALU_LO   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (XALU_Start) begin
            if (is_md) begin
              pend_hi   <= res_hi;
              pend_lo   <= res_lo;
              cnt       <= cnt_load;
              XALU_Busy <= 1'b1;
              state     <= RUN;
            end else if (XALU_Op == XALU_MTHI) begin
              XALU_HI <= A_E;
            end else if (XALU_Op == XALU_MTLO) begin
              XALU_LO <= A_E;
            end
          end
        end
        RUN: begin
          if (cnt == 32'd0) begin
            XALU_HI   <= pend_hi;
            XALU_LO   <= pend_lo;
            XALU_Busy <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core.
- Owns the architectural HI and LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives XALU_HI and XALU_LO into the downstream HI/LO select mux, which produces XALUOut for MFHI/MFLO writeback.
- Exports a registered busy flag so the hazard unit can stall dependent MD instructions.

Parameters:
- MULT_CYCLES, 5, cycles from a sampled MULT/MULTU start until HI/LO commit (must be >= 1).
- DIV_CYCLES, 10, cycles from a sampled DIV/DIVU start until HI/LO commit (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- A_E  input  32  rs operand in EX.
- B_E  input  32  rt operand in EX.
- XALU_Start  input  1  one-cycle request to begin the operation on XALU_Op.
- XALU_Op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
- XALU_Busy  output  1  high while an operation is in flight (registered).
- XALU_HI  output  32  architectural HI register.
- XALU_LO  output  32  architectural LO register.

Behaviour:
- Reset (reset low, asynchronous): XALU_HI=0, XALU_LO=0, XALU_Busy=0, counter=0, pending results=0, state=IDLE.
- State machine has two states: IDLE and RUN.
- IDLE, Start sampled with a MULT/MULTU/DIV/DIVU op at edge N:
  - Operands are captured, the result is computed into the pending HI/LO registers, and the counter is loaded with the cycle count minus 1.
  - XALU_Busy goes high after edge N and the state moves to RUN.
- RUN:
  - The counter decrements each edge.
  - At edge N+MULT_CYCLES (or N+DIV_CYCLES), the pending values are copied to XALU_HI/XALU_LO, XALU_Busy drops at that same edge, and the state returns to IDLE.
  - XALU_HI/XALU_LO keep their old values for the whole RUN interval.
- MTHI/MTLO in IDLE: at the sampling edge, XALU_HI (or XALU_LO) takes A_E. The other register is unchanged and Busy stays 0.
- Start while in RUN: ignored for any op. The hazard unit guarantees this does not happen, and the bench checks that it is ignored.
- Undefined op codes (110, 111) with Start: no effect.
- MULT: {HI,LO} = signed 64-bit product of A_E and B_E.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- DIV overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (DIV or DIVU with B_E=0): Busy still runs for DIV_CYCLES, but HI/LO are unchanged at commit.
- Reset asserted mid-operation: the operation is aborted immediately. Busy=0, HI=LO=0, and no commit occurs after release.
- Start and reset release in the same cycle: Start is honoured only if it is sampled at an edge where reset is high.

Decomposition:
- A shared package xalu_pkg holds:
  - op encodings XALU_MULT, XALU_MULTU, XALU_DIV, XALU_DIVU, XALU_MTHI, XALU_MTLO;
  - state constants IDLE and RUN;
  - default cycle counts.
- Arithmetic is done in-block with full-width 64-bit multiply and 32-bit divide/modulo operators.
- No sub-module is required. The divide sign and overflow fix-up stays local.

Test Plan:
- MULT with A=0xFFFFFFFF, B=0x00000002 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; HI/LO unchanged during Busy.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with A=7, B=2 -> LO=3, HI=1.
- DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU by B=0 with HI=0x1234, LO=0x5678 preset via MTHI/MTLO -> Busy for 10 cycles, then HI/LO still 0x1234/0x5678.
- MTHI with A=0xDEADBEEF -> HI updates at the next edge, Busy stays 0, LO unchanged.
- Reset mid-operation: assert reset low 2 cycles into a MULT -> Busy and HI/LO are 0 immediately. After release they stay 0 with no late commit.
- Start with MTLO while Busy -> LO unchanged.
